// File: rtl/elf_pkg.sv
// elf_pkg: shared owner encoding and RAM geometry/default constants
// for the ELF program/video RAM arbiter.
package elf_pkg;

    localparam int RAM_AW = 12;
    localparam int RAM_DW = 8;

    localparam logic [RAM_AW-1:0] WR_LO_DEF       = 12'h800;
    localparam logic [RAM_AW-1:0] WR_HI_DEF       = 12'hA00;
    localparam logic [RAM_AW-1:0] LOAD_OFFSET_DEF = 12'h400;
    localparam int                MAX_DMA_RUN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CPU  = 2'd2,
        DMA  = 2'd3
    } owner_t;

endpackage

// File: rtl/elf_rd_return.sv
// elf_rd_return: 1-deep read tag pipeline; steers registered ram_q to the
// CPU or DMA requester one cycle after launch and holds rdata otherwise.
// Ports: clk, reset (async high), launch (read issued this cycle),
//   owner (registered owner of the previous RAM cycle), ram_q,
//   cpu_rvalid/cpu_rdata, dma_rvalid/dma_rdata.
module elf_rd_return
    import elf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              launch,
    input  owner_t            owner,
    input  logic [RAM_DW-1:0] ram_q,
    output logic              cpu_rvalid,
    output logic [RAM_DW-1:0] cpu_rdata,
    output logic              dma_rvalid,
    output logic [RAM_DW-1:0] dma_rdata
);

    logic              rd_v;
    logic [RAM_DW-1:0] cpu_hold;
    logic [RAM_DW-1:0] dma_hold;

    // The owner tag is the arbiter's registered state, so only the
    // "a read was launched" bit needs to be tracked here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_v <= 1'b0;
        end else begin
            rd_v <= launch;
        end
    end

    assign cpu_rvalid = rd_v && (owner == CPU);
    assign dma_rvalid = rd_v && (owner == DMA);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_hold <= '0;
            dma_hold <= '0;
        end else begin
            if (cpu_rvalid) cpu_hold <= ram_q;
            if (dma_rvalid) dma_hold <= ram_q;
        end
    end

    assign cpu_rdata = cpu_rvalid ? ram_q : cpu_hold;
    assign dma_rdata = dma_rvalid ? ram_q : dma_hold;

endmodule

// File: rtl/elf_ram_arbiter.sv
// elf_ram_arbiter: single owner of the ELF 4 KiB RAM port A. Arbitrates
// loader > DMA > CPU (with a DMA run limit), issues one RAM command per
// cycle, returns read data, stalls the CPU while locked out.
// Ports: clk, reset (async high); loader dl_*; CPU cpu_req/we/addr/wdata,
//   cpu_gnt/rvalid/rdata/wait; DMA dma_req/addr, dma_gnt/rvalid/rdata;
//   RAM ram_addr/we/wdata, ram_q; wp_hit (dropped CPU write pulse).
// Option: define ELF_ARB_WRPROT_EN to enforce the CPU write window.
module elf_ram_arbiter
    import elf_pkg::*;
#(
    parameter int            AW          = RAM_AW,
    parameter logic [AW-1:0] LOAD_OFFSET = LOAD_OFFSET_DEF,
    parameter logic [AW-1:0] WR_LO       = WR_LO_DEF,
    parameter logic [AW-1:0] WR_HI       = WR_HI_DEF,
    parameter int            MAX_DMA_RUN = MAX_DMA_RUN_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dl_active,
    input  logic [7:0]    dl_index,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [7:0]    dl_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [15:0]   cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_wait,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [7:0]    dma_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_q,
    output logic          wp_hit
);

    localparam int RUN_W = $clog2(MAX_DMA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DMA_RUN);

    owner_t           state;
    owner_t           next_state;
    logic [RUN_W-1:0] dma_run;
    logic             rd_launch;
    logic             in_win;
    logic             unused_bits;

    assign unused_bits = ^{dl_addr[24:AW], cpu_addr[15:AW], WR_LO, WR_HI};

`ifdef ELF_ARB_WRPROT_EN
    assign in_win = (cpu_addr[AW-1:0] >= WR_LO) &&
                    (cpu_addr[AW-1:0] <  WR_HI);
`else
    assign in_win = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Winner selection and RAM command; reset forces IDLE so every
    // output reads 0 while reset is held.
    always_comb begin
        next_state = IDLE;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;
        cpu_gnt    = 1'b0;
        dma_gnt    = 1'b0;
        wp_hit     = 1'b0;
        rd_launch  = 1'b0;

        if (reset) begin
            next_state = IDLE;
        end else if (dl_active) begin
            next_state = LOAD;
        end else if (dma_req && !(cpu_req && dma_run == RUN_MAX)) begin
            next_state = DMA;
        end else if (cpu_req) begin
            next_state = CPU;
        end

        unique case (next_state)
            LOAD: begin
                ram_addr  = dl_addr[AW-1:0] +
                            ((dl_index != 8'd0) ? LOAD_OFFSET : '0);
                ram_we    = dl_wr;
                ram_wdata = dl_data;
            end
            DMA: begin
                ram_addr  = dma_addr;
                dma_gnt   = 1'b1;
                rd_launch = 1'b1;
            end
            CPU: begin
                ram_addr = cpu_addr[AW-1:0];
                cpu_gnt  = 1'b1;
                if (cpu_we) begin
                    ram_wdata = cpu_wdata;
                    ram_we    = in_win;
                    wp_hit    = ~in_win;
                end else begin
                    rd_launch = 1'b1;
                end
            end
            IDLE: begin
            end
        endcase
    end

    assign cpu_wait = ~reset & ((cpu_req & ~cpu_gnt) | dl_active);

    // Counts DMA grants that overtook a waiting CPU; at the limit the
    // next slot goes to the CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dma_run <= '0;
        end else if (cpu_gnt || !cpu_req) begin
            dma_run <= '0;
        end else if (dma_gnt && dma_run != RUN_MAX) begin
            dma_run <= dma_run + RUN_W'(1);
        end
    end

    elf_rd_return u_rd_return (
        .clk        (clk),
        .reset      (reset),
        .launch     (rd_launch),
        .owner      (state),
        .ram_q      (ram_q),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata)
    );

endmodule

// File: tb/tb_elf_ram_arbiter.sv
// tb_elf_ram_arbiter: directed self-checking bench for elf_ram_arbiter
// with a behavioural 1-cycle-latency RAM on port A.
module tb_elf_ram_arbiter;

`ifdef ELF_ARB_WRPROT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_active;
    logic [7:0]  dl_index;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        cpu_wait;
    logic        dma_req;
    logic [11:0] dma_addr;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_q;
    logic        wp_hit;

    logic [7:0]  mem [0:4095];
    logic [42:0] all_outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    elf_ram_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .dl_active  (dl_active),
        .dl_index   (dl_index),
        .dl_wr      (dl_wr),
        .dl_addr    (dl_addr),
        .dl_data    (dl_data),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_wait   (cpu_wait),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_q      (ram_q),
        .wp_hit     (wp_hit)
    );

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_q <= mem[ram_addr];
    end

    assign all_outs = {cpu_gnt, cpu_rvalid, cpu_rdata, cpu_wait,
                       dma_gnt, dma_rvalid, dma_rdata,
                       ram_addr, ram_we, ram_wdata, wp_hit};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dl_active = 0; dl_index = 0; dl_wr = 0; dl_addr = 0; dl_data = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123; cpu_wdata = 0;
        dma_req = 1; dma_addr = 12'h010;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs !== 43'd0) begin
            errors++;
            $display("FAIL reset_outs got %h want 0", all_outs);
        end
        cpu_req = 0;
        dma_req = 0;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_load();
        dl_active = 1; dl_index = 8'd1; dl_wr = 1;
        dl_addr = 25'h010; dl_data = 8'h5A;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123;
        @(negedge clk);
        checks++;
        if ({ram_addr, ram_we, ram_wdata} !== {12'h410, 1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL load_cmd got %h/%b/%h want 410/1/5a",
                     ram_addr, ram_we, ram_wdata);
        end
        checks++;
        if ({cpu_wait, cpu_gnt, dma_gnt} !== 3'b100) begin
            errors++;
            $display("FAIL load_lockout got %b want 100",
                     {cpu_wait, cpu_gnt, dma_gnt});
        end
        tick();
        dl_addr = 25'h0C05; dl_data = 8'h3C;
        @(negedge clk);
        checks++;
        if (ram_addr !== 12'h005) begin
            errors++;
            $display("FAIL load_wrap got %h want 005", ram_addr);
        end
        tick();
        dl_index = 8'd0; dl_addr = 25'h123; dl_data = 8'h9C;
        @(negedge clk);
        checks++;
        if ({ram_addr, ram_we} !== {12'h123, 1'b1}) begin
            errors++;
            $display("FAIL load_idx0 got %h/%b want 123/1", ram_addr, ram_we);
        end
        tick();
        dl_wr = 0; dl_addr = 25'h200;
        @(negedge clk);
        checks++;
        if ({ram_addr, ram_we} !== {12'h200, 1'b0}) begin
            errors++;
            $display("FAIL load_nowr got %h/%b want 200/0", ram_addr, ram_we);
        end
        tick();
    endtask

    task automatic test_cpu_read();
        dl_active = 0;
        @(negedge clk);
        checks++;
        if ({cpu_gnt, cpu_wait, ram_addr, ram_we} !== {2'b10, 12'h123, 1'b0}) begin
            errors++;
            $display("FAIL cpu_rd_gnt got %b%b/%h/%b want 10/123/0",
                     cpu_gnt, cpu_wait, ram_addr, ram_we);
        end
        tick();
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_gnt, cpu_rdata} !== {2'b10, 8'h9C}) begin
            errors++;
            $display("FAIL cpu_rd_data got %b%b/%h want 10/9c",
                     cpu_rvalid, cpu_gnt, cpu_rdata);
        end
        tick();
        cpu_req = 1; cpu_addr = 16'hF410;
        tick();
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h5A}) begin
            errors++;
            $display("FAIL cpu_rd_loaded got %b/%h want 1/5a",
                     cpu_rvalid, cpu_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL cpu_rd_hold got %b/%h want 0/5a",
                     cpu_rvalid, cpu_rdata);
        end
        tick();
    endtask

    task automatic test_load_inflight();
        cpu_req = 1; cpu_addr = 16'h0123;
        tick();
        cpu_req = 0; dl_active = 1; dl_wr = 0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata, cpu_wait} !== {1'b1, 8'h9C, 1'b1}) begin
            errors++;
            $display("FAIL load_inflight got %b/%h/%b want 1/9c/1",
                     cpu_rvalid, cpu_rdata, cpu_wait);
        end
        tick();
        dl_active = 0;
        tick();
    endtask

    task automatic test_wrprot();
        logic [15:0] addrs [3];
        logic        exp_we [3];
        addrs[0] = 16'h07FF; addrs[1] = 16'h0900; addrs[2] = 16'h0A00;
        exp_we[0] = !WP; exp_we[1] = 1'b1; exp_we[2] = !WP;
        cpu_req = 1; cpu_we = 1; cpu_wdata = 8'h77;
        for (int i = 0; i < 3; i++) begin
            cpu_addr = addrs[i];
            @(negedge clk);
            checks++;
            if ({cpu_gnt, ram_we, wp_hit, ram_addr, ram_wdata} !==
                {1'b1, exp_we[i], !exp_we[i], addrs[i][11:0], 8'h77}) begin
                errors++;
                $display("FAIL wr_%h got g%b we%b wp%b a%h d%h want we%b",
                         addrs[i], cpu_gnt, ram_we, wp_hit, ram_addr,
                         ram_wdata, exp_we[i]);
            end
            tick();
        end
        cpu_req = 0; cpu_we = 0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, wp_hit} !== 2'b00) begin
            errors++;
            $display("FAIL wr_no_rvalid got %b want 00", {cpu_rvalid, wp_hit});
        end
        tick();
        cpu_req = 1; cpu_addr = 16'h07FF;
        tick();
        cpu_addr = 16'h0900;
        @(negedge clk);
        checks++;
        if (cpu_rdata !== (WP ? 8'h00 : 8'h77)) begin
            errors++;
            $display("FAIL wr_rb_7ff got %h want %h", cpu_rdata,
                     WP ? 8'h00 : 8'h77);
        end
        tick();
        cpu_req = 0;
        @(negedge clk);
        checks++;
        if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h77}) begin
            errors++;
            $display("FAIL wr_rb_900 got %b/%h want 1/77",
                     cpu_rvalid, cpu_rdata);
        end
        tick();
        tick();
    endtask

    task automatic test_dma_starve();
        logic prev_dma = 1'b0;
        logic prev_cpu = 1'b0;
        logic exp_cpu;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0123;
        dma_req = 1; dma_addr = 12'h410;
        for (int k = 0; k < 27; k++) begin
            exp_cpu = ((k % 9) == 8);
            @(negedge clk);
            checks++;
            if ({dma_gnt, cpu_gnt, dma_rvalid, cpu_rvalid, cpu_wait} !==
                {!exp_cpu, exp_cpu, prev_dma, prev_cpu, !exp_cpu}) begin
                errors++;
                $display("FAIL starve_k%0d got %b want %b", k,
                         {dma_gnt, cpu_gnt, dma_rvalid, cpu_rvalid, cpu_wait},
                         {!exp_cpu, exp_cpu, prev_dma, prev_cpu, !exp_cpu});
            end
            if (dma_rvalid) begin
                checks++;
                if (dma_rdata !== 8'h5A) begin
                    errors++;
                    $display("FAIL starve_dma_data k%0d got %h want 5a",
                             k, dma_rdata);
                end
            end
            if (cpu_rvalid) begin
                checks++;
                if (cpu_rdata !== 8'h9C) begin
                    errors++;
                    $display("FAIL starve_cpu_data k%0d got %h want 9c",
                             k, cpu_rdata);
                end
            end
            prev_dma = !exp_cpu;
            prev_cpu = exp_cpu;
            tick();
        end
        cpu_req = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if ({dma_gnt, cpu_gnt, cpu_wait} !== 3'b100) begin
                errors++;
                $display("FAIL dma_only_k%0d got %b want 100", k,
                         {dma_gnt, cpu_gnt, cpu_wait});
            end
            tick();
        end
        dma_req = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        dma_req = 1; dma_addr = 12'h410;
        @(negedge clk);
        checks++;
        if (dma_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_gnt got %b want 1", dma_gnt);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (all_outs !== 43'd0) begin
            errors++;
            $display("FAIL rst_mid_outs got %h want 0", all_outs);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        dma_req = 0;
        @(negedge clk);
        checks++;
        if (all_outs !== 43'd0) begin
            errors++;
            $display("FAIL rst_idle_outs got %h want 0", all_outs);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        ram_q = 8'h00;
        test_reset();
        test_load();
        test_cpu_read();
        test_load_inflight();
        test_wrprot();
        test_dma_starve();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
